// File: rtl/ap_unsi_mult_pipe.sv
// Two-stage approximate unsigned multiplier: OR-compressed low columns, exact high columns.
// Define AP_MULT_COMP_EN to feed a carry into the accurate region from the top approximate column.
module ap_unsi_mult_pipe #(
  parameter int WIDTH    = 8,
  parameter int APX_COLS = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_res,
  input  logic               err_clr,
  output logic [15:0]        err_cnt
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0] col [PW];
  logic [PW-1:0] acc;
  logic [PW-1:0] apx;
  logic [PW-1:0] apx_res;
  logic [PW-1:0] exact;
  logic          cin;

  logic [PW-1:0] r1_apx;
  logic [PW-1:0] r1_exact;
  logic          v1;
  logic          v2;
  logic          mis;
  logic          en1;
  logic          en2;

  always_comb begin
    for (int c = 0; c < PW; c++)
      col[c] = '0;
    for (int i = 0; i < WIDTH; i++)
      for (int j = 0; j < WIDTH; j++)
        col[i+j] = col[i+j] + CW'(in_a[i] & in_b[j]);
  end

  // Low columns collapse to an OR; only high columns are weighted and summed.
  always_comb begin
    acc = '0;
    apx = '0;
    cin = 1'b0;
    for (int c = 0; c < PW; c++) begin
      if (c < APX_COLS)
        apx[c] = |col[c];
      else
        acc = acc + (PW'(col[c]) << c);
`ifdef AP_MULT_COMP_EN
      if (c == APX_COLS - 1 && col[c] > CW'(1))
        cin = 1'b1;
`endif
    end
    apx_res = (acc + (PW'(cin) << APX_COLS)) | apx;
  end

  assign exact = PW'(in_a) * PW'(in_b);

  assign en2       = !v2 | out_ready;
  assign en1       = !v1 | en2;
  assign in_ready  = en1;
  assign out_valid = v2;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      r1_apx   <= '0;
      r1_exact <= '0;
      out_res  <= '0;
      mis      <= 1'b0;
      err_cnt  <= '0;
    end else begin
      if (en1) begin
        v1 <= in_valid;
        if (in_valid) begin
          r1_apx   <= apx_res;
          r1_exact <= exact;
        end
      end
      if (en2) begin
        v2 <= v1;
        if (v1) begin
          out_res <= r1_apx;
          mis     <= r1_apx != r1_exact;
        end
      end
      if (err_clr)
        err_cnt <= '0;
      else if (v2 && out_ready && mis && err_cnt != 16'hFFFF)
        err_cnt <= err_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_ap_unsi_mult_pipe.sv
// Directed bench for ap_unsi_mult_pipe: APX_COLS=8 instance plus an exact APX_COLS=0 twin.
// Expected values follow AP_MULT_COMP_EN when the bench is built with it.
module tb_ap_unsi_mult_pipe;

`ifdef AP_MULT_COMP_EN
  localparam bit COMP = 1'b1;
`else
  localparam bit COMP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_ready0;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        out_valid;
  logic        out_valid0;
  logic        out_ready;
  logic [15:0] out_res;
  logic [15:0] out_res0;
  logic        err_clr;
  logic [15:0] err_cnt;
  logic [15:0] err_cnt0;

  always #5 clk = ~clk;

  ap_unsi_mult_pipe #(.WIDTH(8), .APX_COLS(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res),
    .err_clr(err_clr), .err_cnt(err_cnt)
  );

  ap_unsi_mult_pipe #(.WIDTH(8), .APX_COLS(0)) dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready0),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid0), .out_ready(out_ready),
    .out_res(out_res0),
    .err_clr(err_clr), .err_cnt(err_cnt0)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] r_off;
    logic [15:0] r_on;
    logic [15:0] ex;
  } vec_t;

  localparam int NV = 10;
  vec_t tv [NV];

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_err = '0;
  logic [15:0] bp_res [3];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Caller is at a negedge with an empty pipeline and out_ready high.
  task automatic run_vec(input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] r, input logic [15:0] ex);
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    #1;
    chk("in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bubble", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'd1);
    chk("out_res", 32'(out_res), 32'(r));
    chk("out_res_exact", 32'(out_res0), 32'(ex));
    if (r != ex)
      exp_err = exp_err + 16'd1;
    @(posedge clk);
    #1;
    chk("err_cnt", 32'(err_cnt), 32'(exp_err));
    chk("err_cnt_exact", 32'(err_cnt0), 32'd0);
    chk("drained", 32'(out_valid), 32'd0);
  endtask

  initial begin
    tv[0] = '{8'hFF, 8'hFF, 16'hF7FF, 16'hF8FF, 16'hFE01};
    tv[1] = '{8'h03, 8'h05, 16'h000F, 16'h000F, 16'h000F};
    tv[2] = '{8'h00, 8'h5A, 16'h0000, 16'h0000, 16'h0000};
    tv[3] = '{8'h01, 8'hFF, 16'h00FF, 16'h00FF, 16'h00FF};
    tv[4] = '{8'h10, 8'h10, 16'h0100, 16'h0100, 16'h0100};
    tv[5] = '{8'h0F, 8'h0F, 16'h007F, 16'h007F, 16'h00E1};
    tv[6] = '{8'h80, 8'h80, 16'h4000, 16'h4000, 16'h4000};
    tv[7] = '{8'hF0, 8'h0F, 16'h0BF0, 16'h0CF0, 16'h0E10};
    tv[8] = '{8'h11, 8'h11, 16'h0111, 16'h0111, 16'h0121};
    tv[9] = '{8'h81, 8'h81, 16'h4081, 16'h4181, 16'h4101};
    bp_res[0] = 16'h000F;
    bp_res[1] = 16'h0100;
    bp_res[2] = 16'h4000;

    // Reset with a pair offered: it must not be taken.
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_a      = 8'hFF;
    in_b      = 8'hFF;
    out_ready = 1'b1;
    err_clr   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_res", 32'(out_res), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;

    for (int k = 0; k < NV; k++) begin
      if (k != 0)
        @(negedge clk);
      run_vec(tv[k].a, tv[k].b, COMP ? tv[k].r_on : tv[k].r_off, tv[k].ex);
    end

    // Backpressure: two pairs fill the pipe, the third waits.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_a      = 8'h03;
    in_b      = 8'h05;
    #1 chk("bp_rdy0", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_a = 8'h10;
    in_b = 8'h10;
    #1 chk("bp_rdy1", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_a = 8'h80;
    in_b = 8'h80;
    #1 chk("bp_rdy2", 32'(in_ready), 32'd0);
    chk("bp_res_hold0", 32'(out_res), 32'(bp_res[0]));
    @(posedge clk);
    @(negedge clk);
    chk("bp_rdy3", 32'(in_ready), 32'd0);
    chk("bp_res_hold1", 32'(out_res), 32'(bp_res[0]));
    out_ready = 1'b1;
    #1 chk("bp_rdy_release", 32'(in_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_res", 32'(out_res), 32'(bp_res[k]));
      chk("bp_res_exact", 32'(out_res0), 32'(bp_res[k]));
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
    chk("bp_empty", 32'(out_valid), 32'd0);
    chk("bp_err_cnt", 32'(err_cnt), 32'(exp_err));

    // Clear wins over a mismatching handshake in the same cycle.
    @(negedge clk);
    in_a     = 8'hFF;
    in_b     = 8'hFF;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("clr_valid", 32'(out_valid), 32'd1);
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    exp_err = '0;
    chk("clr_err_cnt", 32'(err_cnt), 32'd0);

    @(negedge clk);
    run_vec(tv[0].a, tv[0].b, COMP ? tv[0].r_on : tv[0].r_off, tv[0].ex);

    // Reset with both stages full.
    @(negedge clk);
    out_ready = 1'b0;
    in_a      = 8'hFF;
    in_b      = 8'hFF;
    in_valid  = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("full_rdy", 32'(in_ready), 32'd0);
    @(negedge clk);
    in_valid  = 1'b0;
    rst       = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    exp_err = '0;
    chk("frst_valid", 32'(out_valid), 32'd0);
    chk("frst_res", 32'(out_res), 32'd0);
    chk("frst_err_cnt", 32'(err_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("no_stale", 32'(out_valid), 32'd0);
      chk("no_stale_exact", 32'(out_valid0), 32'd0);
    end
    chk("post_rst_err", 32'(err_cnt), 32'd0);

    @(negedge clk);
    run_vec(tv[7].a, tv[7].b, COMP ? tv[7].r_on : tv[7].r_off, tv[7].ex);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ap_unsi_mult_pipe.md
AP_UNSI_MULT_PIPE -- requirements
Module: ap_unsi_mult_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal even values 4..16.
REQ-002 Parameter APX_COLS, default 8, number of low product columns computed approximately; legal 0..2*WIDTH-1.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port in_valid  input  1  operand pair on in_a/in_b is valid.
REQ-006 Port in_ready  output  1  block accepts an operand pair this cycle.
REQ-007 Port in_a, in_b  input  WIDTH each  unsigned operands.
REQ-008 Port out_valid  output  1  out_res holds a valid result.
REQ-009 Port out_ready  input  1  downstream accepts out_res this cycle.
REQ-010 Port out_res  output  2*WIDTH  approximate unsigned product.
REQ-011 Port err_clr  input  1  synchronous clear of err_cnt.
REQ-012 Port err_cnt  output  16  count of delivered results that differ from the exact product.

Function
REQ-013 Partial products: pp(i,j) = in_a[i] & in_b[j]; column c holds every pp with i+j = c.
REQ-014 Approximate columns c < APX_COLS: result bit c = OR of all pp bits in column c; no carry leaves the approximate region.
REQ-015 Accurate region: out_res[2W-1:APX_COLS] = (sum over c >= APX_COLS of popcount(column c) * 2^(c-APX_COLS) + cin), truncated to 2W-APX_COLS bits; cin = 0 unless REQ-027 applies.
REQ-016 APX_COLS = 0 yields the exact product.
REQ-017 Two-stage pipeline: stage 1 registers compressed column sums; stage 2 registers out_res and the exact/approximate mismatch flag; valid flags v1, v2.
REQ-018 en2 = !v2 | out_ready; en1 = !v1 | en2; in_ready = en1 (combinational, no dependence on in_valid).
REQ-019 Transfer on in_valid & in_ready; the accepted pair appears on out_res with out_valid = 1 after exactly 2 rising edges when out_ready is held high.
REQ-020 With out_ready low, out_res/out_valid hold stable; v1 keeps its data; in_ready = 0 once v1 & v2 are both set.
REQ-021 Simultaneous output drain and input accept in the same cycle with a full pipeline sustains throughput of one result per cycle with no loss or duplication.
REQ-022 err_cnt increments by 1 on each output handshake (out_valid & out_ready) whose out_res != in_a*in_b; saturates at 0xFFFF.
REQ-023 err_clr has priority over increment: err_cnt = 0 on the next edge even when a mismatching handshake occurs in the same cycle.

Reset
REQ-024 rst = 1 on an edge: v1 = v2 = 0, out_valid = 0, out_res = 0, err_cnt = 0; in-flight data is discarded.
REQ-025 During rst, in_ready = 1 as per REQ-018 (both valids clear); pairs presented in the reset cycle are not accepted.
REQ-026 Deasserting rst mid-stream requires no flush cycle; the first accept may occur on the first edge after deassertion.

Configuration
REQ-027 Macro AP_MULT_COMP_EN defined: cin = 1 when column APX_COLS-1 holds at least two set pp bits (APX_COLS >= 1); undefined: cin = 0 always; the stage-1 path and latency are identical in both cases.

Verification
REQ-028 WIDTH=8, APX_COLS=8, macro off: a=0xFF, b=0xFF -> out_res=0xF7FF after 2 edges; err_cnt 0->1.
REQ-029 Same as REQ-028 with AP_MULT_COMP_EN defined -> out_res=0xF8FF; err_cnt=1.
REQ-030 WIDTH=8, APX_COLS=8: a=0x03, b=0x05 -> out_res=0x000F; err_cnt unchanged.
REQ-031 WIDTH=8, APX_COLS=0: a=0xFF, b=0xFF -> out_res=0xFE01; err_cnt stays 0.
REQ-032 Backpressure: out_ready=0, present 3 pairs back-to-back -> first 2 accepted, in_ready=0 from then; raise out_ready -> 3 results in order, one per cycle.
REQ-033 Assert rst with v1=v2=1 -> out_valid=0, err_cnt=0 next edge; no stale result emerges afterwards.
